// File: rtl/dram_cache_ctrl_pkg.sv
// Shared definitions for the direct-mapped write-through word cache controller:
// state codes, default geometry and the tag-width helper.
package dram_cache_ctrl_pkg;

    localparam int unsigned DefIndexBits = 10;

    typedef enum logic [6:0] {
        StInit   = 7'd0,
        StIdle   = 7'd1,
        StLookup = 7'd2,
        StFill   = 7'd3,
        StWrite  = 7'd4
    } state_e;

    // Word-addressed cache: two byte-offset bits sit below the index.
    function automatic int unsigned tag_bits(int unsigned addr_width, int unsigned index_bits);
        return addr_width - index_bits - 2;
    endfunction

endpackage

// File: rtl/cache_line_ram.sv
// Data/tag/valid line arrays with one-cycle synchronous read and a byte-masked write port.
// Read outputs hold their value until the next read strobe.
module cache_line_ram #(
    parameter int unsigned IndexBits = 10,
    parameter int unsigned TagBits   = 20
) (
    input  logic                 clk,
    input  logic                 rd_en,
    input  logic [IndexBits-1:0] rd_idx,
    output logic [31:0]          rd_data,
    output logic [TagBits-1:0]   rd_tag,
    output logic                 rd_valid,
    input  logic                 wr_en,
    input  logic [IndexBits-1:0] wr_idx,
    input  logic [3:0]           wr_mask,
    input  logic [31:0]          wr_data,
    input  logic [TagBits-1:0]   wr_tag,
    input  logic                 wr_valid
);

    localparam int unsigned Lines = 1 << IndexBits;

    logic [31:0]        data_mem  [Lines];
    logic [TagBits-1:0] tag_mem   [Lines];
    logic               valid_mem [Lines];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask[b]) begin
                    data_mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
            tag_mem[wr_idx]   <= wr_tag;
            valid_mem[wr_idx] <= wr_valid;
        end
        if (rd_en) begin
            rd_data  <= data_mem[rd_idx];
            rd_tag   <= tag_mem[rd_idx];
            rd_valid <= valid_mem[rd_idx];
        end
    end

endmodule

// File: rtl/dram_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate word cache between the AHB SRAM bridge
// and a request/acknowledge memory backend. !o_busy acts as HREADY on the user side.
module dram_cache_ctrl
    import dram_cache_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned INDEX_BITS = DefIndexBits
) (
    input  logic                  clk,
    input  logic                  rst_x,
    input  logic                  i_rd_en,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_data,
    input  logic [3:0]            i_mask,
    output logic [31:0]           o_data,
    output logic                  o_busy,
    output logic                  w_init_done,
    output logic [6:0]            state,
    output logic                  c_oe,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_mask,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ack
);

    localparam int unsigned TagBits = tag_bits(ADDR_WIDTH, INDEX_BITS);

    state_e                  state_q, state_d;
    logic [INDEX_BITS-1:0]   cnt_q, cnt_d;
    logic                    init_done_q, init_done_d;
    logic [ADDR_WIDTH-3:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              mask_q, mask_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    fill_oe_q, fill_oe_d;
    logic                    wr_done_q, wr_done_d;
    logic                    wr_block_q, wr_block_d;

    logic                    ram_rd_en;
    logic [INDEX_BITS-1:0]   ram_rd_idx;
    logic [31:0]             ram_rd_data;
    logic [TagBits-1:0]      ram_rd_tag;
    logic                    ram_rd_valid;
    logic                    ram_wr_en;
    logic [INDEX_BITS-1:0]   ram_wr_idx;
    logic [3:0]              ram_wr_mask;
    logic [31:0]             ram_wr_data;
    logic                    ram_wr_valid;

    logic                    hit, accept_ok, wr_go, rd_go;
    logic                    unused_addr;

    assign unused_addr = ^i_addr[1:0];

    cache_line_ram #(
        .IndexBits(INDEX_BITS),
        .TagBits  (TagBits)
    ) u_line_ram (
        .clk     (clk),
        .rd_en   (ram_rd_en),
        .rd_idx  (ram_rd_idx),
        .rd_data (ram_rd_data),
        .rd_tag  (ram_rd_tag),
        .rd_valid(ram_rd_valid),
        .wr_en   (ram_wr_en),
        .wr_idx  (ram_wr_idx),
        .wr_mask (ram_wr_mask),
        .wr_data (ram_wr_data),
        .wr_tag  (addr_q[ADDR_WIDTH-3:INDEX_BITS]),
        .wr_valid(ram_wr_valid)
    );

    assign hit = ram_rd_valid && (ram_rd_tag == addr_q[ADDR_WIDTH-3:INDEX_BITS]);

    // A request is taken in idle, or in a hitting lookup so back-to-back hits stream.
    assign accept_ok = ((state_q == StIdle) && !wr_done_q) || ((state_q == StLookup) && hit);
    assign wr_go     = accept_ok && i_wr_en && !wr_block_q;
    assign rd_go     = accept_ok && i_rd_en && !wr_go;

    // A level write strobe held high is one write; it must drop before the next.
    assign wr_block_d = wr_go ? 1'b1 : (i_wr_en ? wr_block_q : 1'b0);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        init_done_d  = init_done_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mask_d       = mask_q;
        rdata_d      = rdata_q;
        fill_oe_d    = 1'b0;
        wr_done_d    = 1'b0;
        ram_rd_en    = 1'b0;
        ram_rd_idx   = i_addr[INDEX_BITS+1:2];
        ram_wr_en    = 1'b0;
        ram_wr_idx   = addr_q[INDEX_BITS-1:0];
        ram_wr_mask  = 4'hF;
        ram_wr_data  = mem_rdata;
        ram_wr_valid = 1'b1;
        o_busy       = 1'b1;
        c_oe         = fill_oe_q;
        o_data       = rdata_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_mask     = '0;

        unique case (state_q)
            StInit: begin
                ram_wr_en    = 1'b1;
                ram_wr_idx   = cnt_q;
                ram_wr_mask  = 4'h0;
                ram_wr_valid = 1'b0;
                cnt_d        = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    init_done_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            StIdle: begin
                // Stays busy for the cycle after a write acknowledge.
                o_busy = wr_done_q;
            end
            StLookup: begin
                if (hit) begin
                    o_busy  = 1'b0;
                    c_oe    = 1'b1;
                    o_data  = ram_rd_data;
                    rdata_d = ram_rd_data;
                    state_d = StIdle;
                end else begin
                    state_d = StFill;
                end
            end
            StFill: begin
                mem_req  = 1'b1;
                mem_addr = {addr_q, 2'b00};
                mem_mask = 4'hF;
                if (mem_ack) begin
                    ram_wr_en = 1'b1;
                    rdata_d   = mem_rdata;
                    fill_oe_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            StWrite: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {addr_q, 2'b00};
                mem_wdata = wdata_q;
                mem_mask  = mask_q;
                if (mem_ack) begin
                    wr_done_d = 1'b1;
                    state_d   = StIdle;
                    // Lookup result from the accept cycle is still held by the array.
                    if (hit) begin
                        ram_wr_en   = 1'b1;
                        ram_wr_mask = mask_q;
                        ram_wr_data = wdata_q;
                    end
                end
            end
            default: state_d = StInit;
        endcase

        if (wr_go) begin
            addr_d    = i_addr[ADDR_WIDTH-1:2];
            wdata_d   = i_data;
            mask_d    = i_mask;
            ram_rd_en = 1'b1;
            state_d   = StWrite;
        end else if (rd_go) begin
            addr_d    = i_addr[ADDR_WIDTH-1:2];
            ram_rd_en = 1'b1;
            state_d   = StLookup;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_x) begin
            state_q     <= StInit;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mask_q      <= '0;
            rdata_q     <= '0;
            fill_oe_q   <= 1'b0;
            wr_done_q   <= 1'b0;
            wr_block_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
            rdata_q     <= rdata_d;
            fill_oe_q   <= fill_oe_d;
            wr_done_q   <= wr_done_d;
            wr_block_q  <= wr_block_d;
        end
    end

    assign w_init_done = init_done_q;
    assign state       = state_q;

endmodule

// File: tb/tb_dram_cache_ctrl.sv
// Self-checking bench for dram_cache_ctrl: backend memory and cache models predict read data,
// which is queued at the read strobe and compared when the controller signals c_oe.
module tb_dram_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst_x = 1'b1;
    logic        i_rd_en = 1'b0, i_wr_en = 1'b0;
    logic [31:0] i_addr = '0, i_data = '0;
    logic [3:0]  i_mask = '0;
    logic [31:0] o_data;
    logic        o_busy, w_init_done, c_oe, mem_req, mem_we;
    logic [6:0]  state;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_mask;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    int compared = 0;
    int mismatched = 0;
    logic [31:0] exp_q[$];

    bit [31:0] bmem [bit [29:0]];
    bit        mdl_valid [1024];
    bit [19:0] mdl_tag   [1024];
    bit [31:0] mdl_data  [1024];

    always #5 clk = ~clk;

    dram_cache_ctrl dut (
        .clk        (clk),
        .rst_x      (rst_x),
        .i_rd_en    (i_rd_en),
        .i_wr_en    (i_wr_en),
        .i_addr     (i_addr),
        .i_data     (i_data),
        .i_mask     (i_mask),
        .o_data     (o_data),
        .o_busy     (o_busy),
        .w_init_done(w_init_done),
        .state      (state),
        .c_oe       (c_oe),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_mask   (mem_mask),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    function automatic bit [31:0] bmem_rd(input logic [31:0] a);
        return bmem.exists(a[31:2]) ? bmem[a[31:2]] : 32'h0;
    endfunction

    function automatic bit mdl_hit(input logic [31:0] a);
        return mdl_valid[a[11:2]] && (mdl_tag[a[11:2]] == a[31:12]);
    endfunction

    function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] nw,
                                        input bit [3:0] m);
        bit [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (o_busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (o_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL ready_timeout: o_busy=%b required 0", o_busy);
        end
    endtask

    task automatic do_read(input logic [31:0] a, input bit exp_hit, input int lat);
        logic [31:0] exp;
        int n;
        wait_ready();
        exp = mdl_hit(a) ? mdl_data[a[11:2]] : bmem_rd(a);
        exp_q.push_back(exp);
        i_rd_en = 1'b1;
        i_addr  = a;
        @(negedge clk);
        i_rd_en = 1'b0;
        i_addr  = $urandom();
        compared++;
        if (mem_req !== 1'b0) begin
            mismatched++;
            $display("FAIL lookup_req @%h: mem_req=%b required 0", a, mem_req);
        end
        compared++;
        if (o_busy !== !exp_hit) begin
            mismatched++;
            $display("FAIL lookup_busy @%h: o_busy=%b required %b", a, o_busy, !exp_hit);
        end
        if (o_busy) begin
            n = 0;
            while (!mem_req && n < 50) begin
                @(negedge clk);
                n++;
            end
            compared++;
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_mask !== 4'hF
                || mem_addr !== {a[31:2], 2'b00}) begin
                mismatched++;
                $display("FAIL fill_req @%h: req=%b we=%b mask=%h addr=%h required 1 0 f %h",
                         a, mem_req, mem_we, mem_mask, mem_addr, {a[31:2], 2'b00});
            end
            repeat (lat) begin
                @(negedge clk);
                compared++;
                if (mem_req !== 1'b1 || o_busy !== 1'b1) begin
                    mismatched++;
                    $display("FAIL fill_hold @%h: req=%b busy=%b required 1 1", a, mem_req, o_busy);
                end
            end
            mem_ack   = 1'b1;
            mem_rdata = bmem_rd(a);
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = $urandom();
            mdl_valid[a[11:2]] = 1'b1;
            mdl_tag[a[11:2]]   = a[31:12];
            mdl_data[a[11:2]]  = bmem_rd(a);
        end
        compared++;
        if (c_oe !== 1'b1 || o_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL read_done @%h: c_oe=%b busy=%b required 1 0", a, c_oe, o_busy);
        end
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL read_data @%h: no pending expectation", a);
        end else begin
            exp = exp_q.pop_front();
            if (o_data !== exp) begin
                mismatched++;
                $display("FAIL read_data @%h: o_data=%h required %h", a, o_data, exp);
            end
        end
        @(negedge clk);
        compared++;
        if (c_oe !== 1'b0 || o_data !== exp) begin
            mismatched++;
            $display("FAIL read_hold @%h: c_oe=%b o_data=%h required 0 %h", a, c_oe, o_data, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                            input int lat);
        wait_ready();
        i_wr_en = 1'b1;
        i_addr  = a;
        i_data  = d;
        i_mask  = m;
        @(negedge clk);
        i_wr_en = 1'b0;
        i_data  = $urandom();
        compared++;
        if (o_busy !== 1'b1 || mem_req !== 1'b1 || mem_we !== 1'b1 || mem_mask !== m
            || mem_wdata !== d || mem_addr !== {a[31:2], 2'b00}) begin
            mismatched++;
            $display("FAIL write_req @%h: busy=%b req=%b we=%b mask=%h wdata=%h addr=%h required 1 1 1 %h %h %h",
                     a, o_busy, mem_req, mem_we, mem_mask, mem_wdata, mem_addr, m, d,
                     {a[31:2], 2'b00});
        end
        repeat (lat) @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        compared++;
        if (o_busy !== 1'b1 || mem_req !== 1'b0) begin
            mismatched++;
            $display("FAIL write_ack1 @%h: busy=%b req=%b required 1 0", a, o_busy, mem_req);
        end
        @(negedge clk);
        compared++;
        if (o_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL write_ack2 @%h: busy=%b required 0", a, o_busy);
        end
        bmem[a[31:2]] = merge(bmem_rd(a), d, m);
        if (mdl_hit(a)) mdl_data[a[11:2]] = merge(mdl_data[a[11:2]], d, m);
    endtask

    task automatic test_reset();
        int n;
        bit saw_req;
        rst_x = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if (o_busy !== 1'b1 || state !== 7'd0 || mem_req !== 1'b0 || c_oe !== 1'b0
            || w_init_done !== 1'b0 || o_data !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_state: busy=%b state=%0d req=%b c_oe=%b done=%b o_data=%h required 1 0 0 0 0 0",
                     o_busy, state, mem_req, c_oe, w_init_done, o_data);
        end
        rst_x   = 1'b0;
        i_rd_en = 1'b1;
        i_addr  = 32'h100;
        n = 0;
        saw_req = 1'b0;
        while (o_busy && n < 1100) begin
            @(negedge clk);
            n++;
            if (n == 10) i_rd_en = 1'b0;
            if (mem_req) saw_req = 1'b1;
        end
        compared++;
        if (n != 1024) begin
            mismatched++;
            $display("FAIL init_len: busy cycles=%0d required 1024", n);
        end
        compared++;
        if (w_init_done !== 1'b1 || state !== 7'd1 || saw_req) begin
            mismatched++;
            $display("FAIL init_done: done=%b state=%0d saw_req=%b required 1 1 0",
                     w_init_done, state, saw_req);
        end
    endtask

    task automatic test_read_miss();
        do_read(32'h100, 1'b0, 5);
    endtask

    task automatic test_read_hit();
        do_read(32'h100, 1'b1, 0);
    endtask

    task automatic test_write_hit();
        do_write(32'h102, 32'h00AA0000, 4'b0100, 2);
        do_read(32'h100, 1'b1, 0);
        compared++;
        if (o_data !== 32'hDEAABEEF) begin
            mismatched++;
            $display("FAIL merged_word: o_data=%h required deaabeef", o_data);
        end
    endtask

    task automatic test_write_miss();
        do_write(32'h2000, 32'h12345678, 4'hF, 0);
        do_read(32'h2000, 1'b0, 3);
    endtask

    task automatic test_alias();
        do_read(32'h1100, 1'b0, 1);
        do_read(32'h100, 1'b0, 2);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        wait_ready();
        exp_q.push_back(mdl_data[10'h040]);
        exp_q.push_back(mdl_data[10'h000]);
        i_rd_en = 1'b1;
        i_addr  = 32'h100;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            i_addr = 32'h2000;
            if (k == 1) i_rd_en = 1'b0;
            compared++;
            if (c_oe !== 1'b1 || o_busy !== 1'b0 || mem_req !== 1'b0 || exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL b2b_flags[%0d]: c_oe=%b busy=%b req=%b required 1 0 0",
                         k, c_oe, o_busy, mem_req);
            end else begin
                exp = exp_q.pop_front();
                compared++;
                if (o_data !== exp) begin
                    mismatched++;
                    $display("FAIL b2b_data[%0d]: o_data=%h required %h", k, o_data, exp);
                end
            end
        end
        @(negedge clk);
        compared++;
        if (c_oe !== 1'b0 || state !== 7'd1) begin
            mismatched++;
            $display("FAIL b2b_end: c_oe=%b state=%0d required 0 1", c_oe, state);
        end
    endtask

    task automatic test_held_write();
        int reqs;
        bit prev;
        wait_ready();
        i_wr_en = 1'b1;
        i_addr  = 32'h104;
        i_data  = 32'h55667788;
        i_mask  = 4'hF;
        reqs = 0;
        prev = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req && !prev) reqs++;
            if (mem_req) mem_ack = 1'b1;
            prev = mem_req;
        end
        mem_ack = 1'b0;
        i_wr_en = 1'b0;
        bmem[30'h41] = 32'h55667788;
        compared++;
        if (reqs != 1 || state !== 7'd1) begin
            mismatched++;
            $display("FAIL held_write: requests=%0d state=%0d required 1 1", reqs, state);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        wait_ready();
        i_rd_en = 1'b1;
        i_addr  = 32'h3000;
        @(negedge clk);
        i_rd_en = 1'b0;
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (mem_req !== 1'b1) begin
            mismatched++;
            $display("FAIL abort_setup: mem_req=%b required 1", mem_req);
        end
        rst_x = 1'b1;
        @(negedge clk);
        rst_x = 1'b0;
        compared++;
        if (mem_req !== 1'b0 || state !== 7'd0 || o_busy !== 1'b1 || w_init_done !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_state: req=%b state=%0d busy=%b done=%b required 0 0 1 0",
                     mem_req, state, o_busy, w_init_done);
        end
        for (int i = 0; i < 1024; i++) mdl_valid[i] = 1'b0;
        do_read(32'h100, 1'b0, 1);
    endtask

    initial begin
        bmem[30'h040]  = 32'hDEADBEEF;
        bmem[30'h440]  = 32'hCAFEF00D;
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_hit();
        test_write_miss();
        test_alias();
        test_back_to_back();
        test_held_write();
        test_reset_mid();
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL pending_reads: left=%0d required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
